// File: rtl/seq_left_shift.sv
// seq_left_shift: multi-cycle logical left shifter, one bit per clock.
// Registers the result with Z/N flags, plus a signed overflow flag (V) and
// the last bit shifted out of the MSB (CO). Shift amounts of zero or at
// least WIDTH finish in a single edge without loading the counter.
module seq_left_shift #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [31:0]      C,
    output logic [WIDTH-1:0] B,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             CO,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             vacc, vacc_nxt;
    logic             coacc, coacc_nxt;

    // Result staged for the output registers on the edge that enters DONE
    logic             load_out;
    logic [WIDTH-1:0] res_b;
    logic             res_v;
    logic             res_co;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath update and result staging
    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        vacc_nxt  = vacc;
        coacc_nxt = coacc;
        load_out  = 1'b0;
        res_b     = work;
        res_v     = vacc;
        res_co    = coacc;

        unique case (state)
            IDLE: begin
                if (start) begin
                    vacc_nxt  = 1'b0;
                    coacc_nxt = 1'b0;
                    if (C == 32'd0) begin
                        work_nxt  = A;
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                        load_out  = 1'b1;
                        res_b     = A;
                        res_v     = 1'b0;
                        res_co    = 1'b0;
                    end else if (C >= 32'(WIDTH)) begin
                        // Every operand bit leaves the word; only an exact
                        // WIDTH shift sees A[0] as the final carry.
                        work_nxt  = '0;
                        cnt_nxt   = '0;
                        vacc_nxt  = (A != '0);
                        coacc_nxt = (C == 32'(WIDTH)) ? A[0] : 1'b0;
                        state_nxt = DONE;
                        load_out  = 1'b1;
                        res_b     = '0;
                        res_v     = vacc_nxt;
                        res_co    = coacc_nxt;
                    end else begin
                        work_nxt  = A;
                        cnt_nxt   = C[CW-1:0];
                        state_nxt = SHIFT;
                    end
                end
            end

            SHIFT: begin
                coacc_nxt = work[WIDTH-1];
                vacc_nxt  = vacc | (work[WIDTH-1] ^ work[WIDTH-2]);
                work_nxt  = {work[WIDTH-2:0], 1'b0};
                cnt_nxt   = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = DONE;
                    load_out  = 1'b1;
                    res_b     = work_nxt;
                    res_v     = vacc_nxt;
                    res_co    = coacc_nxt;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working register, counter and flag accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            cnt   <= '0;
            vacc  <= 1'b0;
            coacc <= 1'b0;
        end else begin
            work  <= work_nxt;
            cnt   <= cnt_nxt;
            vacc  <= vacc_nxt;
            coacc <= coacc_nxt;
        end
    end

    // Output registers: updated only on completion, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            B  <= '0;
            Z  <= 1'b0;
            N  <= 1'b0;
            V  <= 1'b0;
            CO <= 1'b0;
        end else if (load_out) begin
            B  <= res_b;
            Z  <= (res_b == '0);
            N  <= res_b[WIDTH-1];
            V  <= res_v;
            CO <= res_co;
        end
    end

    // Status decoded from the registered state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule
